rv_mem_resp: RTL
================

RV_MEM_RESP -- requirements
Module: rv_mem_resp

Interface
REQ-001 Parameter DPWIDTH, default 32, datapath and memory word width in bits.
REQ-002 Parameter MEMWORDS, default 1024, RAM depth in words; power of two.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  input  DPWIDTH  byte address of instruction fetch from the core.
REQ-006 imem_datain  output  DPWIDTH  instruction word returned to the core.
REQ-007 dmem_addr  input  DPWIDTH  byte address of data access from the core.
REQ-008 dmem_dataout  input  DPWIDTH  store data from the core.
REQ-009 memrw  input  1  1 = write, 0 = read.
REQ-010 dmem_datain  output  DPWIDTH  load data returned to the core.
REQ-011 load_valid  input  1  boot-load word valid.
REQ-012 load_data  input  DPWIDTH  boot-load word.
REQ-013 load_last  input  1  qualifies the final boot-load word.
REQ-014 load_ready  output  1  block accepts boot-load words.
REQ-015 cpu_rst  output  1  reset to the core; 1 holds the core in reset.
REQ-016 io_out  output  DPWIDTH  memory-mapped output register.
REQ-017 halted  output  1  core has executed a halt write.

Function
REQ-018 The FSM SHALL have states BOOT, RUN and HALT.
REQ-019 In BOOT: load_ready=1 and cpu_rst=1; each cycle with load_valid=1 writes load_data to RAM[ptr] and increments ptr.
REQ-020 BOOT->RUN SHALL occur on the edge that accepts a word with load_last=1, or on the edge that writes ptr=MEMWORDS-1.
REQ-021 In RUN: load_ready=0, cpu_rst=0, and load_valid is ignored.
REQ-022 RUN->HALT SHALL occur on the edge of any write (memrw=1) to 0xFFFF_0008; in HALT: halted=1, cpu_rst=1, and all core writes are ignored; HALT exits only via rst.
REQ-023 Address decode: RAM when addr < MEMWORDS*4 (word index = addr[log2(MEMWORDS)+1:2], addr[1:0] ignored); MMIO at 0xFFFF_0000/0004/0008; all other addresses unmapped.
REQ-024 imem_datain SHALL be combinational from RAM at imem_addr; unmapped or MMIO fetches return 32'h0000_0013.
REQ-025 dmem_datain SHALL be registered: updated every edge with the read data at dmem_addr, one-cycle latency.
REQ-026 Same-cycle read and write to one address SHALL return the old value (read-before-write).
REQ-027 Writes from the core (memrw=1) SHALL take effect on the edge only in RUN; memrw in BOOT or HALT is ignored.
REQ-028 0xFFFF_0000: io_out, read/write.
REQ-029 0xFFFF_0004: 32-bit cycle counter, read-only; increments each RUN cycle, wraps 0xFFFF_FFFF->0; writes ignored.
REQ-030 0xFFFF_0008: reads return {31'b0, halted}.
REQ-031 Unmapped reads return 0; unmapped writes are ignored.

Reset
REQ-032 While rst=1 on an edge: state<=BOOT, ptr<=0, io_out<=0, counter<=0, dmem_datain<=0, halted<=0.
REQ-033 While rst=1: cpu_rst=1 and load_ready=0; load_valid is ignored.
REQ-034 RAM contents SHALL NOT be reset.
REQ-035 rst asserted mid-load or mid-run SHALL abort and restart at BOOT with ptr=0.

Verification
REQ-036 Load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F with load_last on word 4 -> cpu_rst falls the next cycle; imem_addr=0x8 reads 0x002081B3.
REQ-037 RUN, write 0xDEADBEEF to 0x40, then read 0x40 -> dmem_datain=0xDEADBEEF one cycle after the read address is applied; same-cycle write 0x1 and read of 0x40 returns 0xDEADBEEF.
REQ-038 Write 0x5A to 0xFFFF_0000 -> io_out=0x5A; read 0xFFFF_0004 on two reads 10 RUN cycles apart -> returned values differ by 10.
REQ-039 Write to 0xFFFF_0008 -> halted=1, cpu_rst=1; a subsequent write 0x7 to 0xFFFF_0000 leaves io_out unchanged; read of 0xFFFF_0008 returns 1.
REQ-040 Stream MEMWORDS words without load_last -> RUN after word MEMWORDS; assert rst mid-load -> ptr=0, cpu_rst=1, and fetch 0x2000 (unmapped) returns 0x00000013.

Source files
------------

// File: rtl/rv_mem_resp.sv
// Memory and MMIO responder for a small RISC-V core. The RAM is boot-loaded
// from a word stream while the core is held in reset, then serves fetches and loads/stores.
module rv_mem_resp #(
  parameter int DPWIDTH  = 32,
  parameter int MEMWORDS = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DPWIDTH-1:0] imem_addr_i,
  output logic [DPWIDTH-1:0] imem_datain_o,
  input  logic [DPWIDTH-1:0] dmem_addr_i,
  input  logic [DPWIDTH-1:0] dmem_dataout_i,
  input  logic               memrw_i,
  output logic [DPWIDTH-1:0] dmem_datain_o,
  input  logic               load_valid_i,
  input  logic [DPWIDTH-1:0] load_data_i,
  input  logic               load_last_i,
  output logic               load_ready_o,
  output logic               cpu_rst_o,
  output logic [DPWIDTH-1:0] io_out_o,
  output logic               halted_o
);

  localparam int AW = $clog2(MEMWORDS);
  localparam logic [DPWIDTH-1:0] RAM_BYTES = DPWIDTH'(MEMWORDS * 4);
  localparam logic [DPWIDTH-1:0] ADDR_IO   = DPWIDTH'(32'hFFFF_0000);
  localparam logic [DPWIDTH-1:0] ADDR_CNT  = DPWIDTH'(32'hFFFF_0004);
  localparam logic [DPWIDTH-1:0] ADDR_HALT = DPWIDTH'(32'hFFFF_0008);
  localparam logic [DPWIDTH-1:0] NOP_INSN  = DPWIDTH'(32'h0000_0013);
  localparam logic [AW-1:0]      PTR_LAST  = AW'(MEMWORDS - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [DPWIDTH-1:0]   io_q, io_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [DPWIDTH-1:0]   rdata_q, rdata_d;
  logic [DPWIDTH-1:0]   mem_q [MEMWORDS];

  logic          boot_we, core_we;
  logic          d_ram, d_io, d_cnt, d_halt, i_ram;
  logic [AW-1:0] d_idx, i_idx;

  assign d_ram  = dmem_addr_i < RAM_BYTES;
  assign d_io   = dmem_addr_i == ADDR_IO;
  assign d_cnt  = dmem_addr_i == ADDR_CNT;
  assign d_halt = dmem_addr_i == ADDR_HALT;
  assign d_idx  = dmem_addr_i[AW+1:2];
  assign i_ram  = imem_addr_i < RAM_BYTES;
  assign i_idx  = imem_addr_i[AW+1:2];

  assign halted_o      = state_q == S_HALT;
  assign cpu_rst_o     = rst_i || (state_q != S_RUN);
  assign load_ready_o  = !rst_i && (state_q == S_BOOT);
  assign io_out_o      = io_q;
  assign dmem_datain_o = rdata_q;
  assign imem_datain_o = i_ram ? mem_q[i_idx] : NOP_INSN;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    io_d    = io_q;
    cnt_d   = cnt_q;
    boot_we = 1'b0;
    core_we = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (load_valid_i) begin
          boot_we = 1'b1;
          ptr_d   = ptr_q + AW'(1);
          if (load_last_i || (ptr_q == PTR_LAST)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (memrw_i) begin
          core_we = d_ram;
          if (d_io) io_d = dmem_dataout_i;
          if (d_halt) state_d = S_HALT;
        end
      end
      S_HALT: ;
      default: state_d = S_BOOT;
    endcase
  end

  // Registered read uses pre-edge RAM contents, giving read-before-write.
  always_comb begin
    rdata_d = '0;
    if (d_ram)       rdata_d = mem_q[d_idx];
    else if (d_io)   rdata_d = io_q;
    else if (d_cnt)  rdata_d = DPWIDTH'(cnt_q);
    else if (d_halt) rdata_d = DPWIDTH'(halted_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_BOOT;
      ptr_q   <= '0;
      io_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      io_q    <= io_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (boot_we)      mem_q[ptr_q] <= load_data_i;
      else if (core_we) mem_q[d_idx] <= dmem_dataout_i;
    end
  end

endmodule
